// File: rtl/if_id.sv
// ----------------------------------------------------------------------------
// if_id: IF/ID pipeline register of the 5-stage core.
//
// Captures the fetched instruction and its word address every rising edge and
// presents them to decode one cycle later. A taken jump/branch (jump_i) loads a
// bubble (NOP_INSTR, address 0) instead of the wrongly fetched instruction.
//
// Optional build macro: IFID_STALL_EN
//   When defined, adds stall_i (after addr_o) which holds the current contents
//   for load-use hazards. Priority: reset > jump_i flush > stall_i hold > load.
//
// Ports:
//   clk      in   pipeline clock, rising edge
//   rst_n    in   asynchronous active-low reset (outputs -> NOP / 0)
//   jump_i   in   flush request, sampled at the rising edge
//   Instr_i  in   [INSTR_W] instruction from fetch
//   addr_i   in   [ADDR_W]  word address of Instr_i
//   Instr_o  out  [INSTR_W] registered instruction to decode
//   addr_o   out  [ADDR_W]  registered address to decode
//   stall_i  in   hold request (IFID_STALL_EN builds only)
// ----------------------------------------------------------------------------
module if_id #(
    parameter int unsigned          INSTR_W   = 32,
    parameter int unsigned          ADDR_W    = 14,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               jump_i,
    input  logic [INSTR_W-1:0] Instr_i,
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [INSTR_W-1:0] Instr_o,
    output logic [ADDR_W-1:0]  addr_o
`ifdef IFID_STALL_EN
    ,
    input  logic               stall_i
`endif
);

    // Hold request; tied off when the stall feature is not built.
    logic hold_c;

`ifdef IFID_STALL_EN
    assign hold_c = stall_i;
`else
    assign hold_c = 1'b0;
`endif

    // Pipeline register: flush beats hold, hold beats load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Instr_o <= NOP_INSTR;
            addr_o  <= '0;
        end else if (jump_i) begin
            Instr_o <= NOP_INSTR;
            addr_o  <= '0;
        end else if (!hold_c) begin
            Instr_o <= Instr_i;
            addr_o  <= addr_i;
        end
    end

endmodule

// File: tb/tb_if_id.sv
// ----------------------------------------------------------------------------
// tb_if_id: self-checking bench for if_id.
// Inputs are driven on the falling edge; the expected register contents are
// computed from the stimulus, pushed to a scoreboard queue, and popped and
// compared 1 time unit after the following rising edge.
// Build with +define+IFID_STALL_EN to also exercise the stall port.
// ----------------------------------------------------------------------------
module tb_if_id;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 14;

`ifdef IFID_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  addr;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               jump;
    logic               stall;
    logic [INSTR_W-1:0] instr_in;
    logic [ADDR_W-1:0]  addr_in;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  addr_out;

    exp_t               sb_q[$];
    exp_t               model;
    int                 n_checks;
    int                 n_pass;

    if_id dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .jump_i  (jump),
        .Instr_i (instr_in),
        .addr_i  (addr_in),
        .Instr_o (instr_out),
        .addr_o  (addr_out)
`ifdef IFID_STALL_EN
        ,
        .stall_i (stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for every check in the bench.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare both outputs against one expected pair.
    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".instr"}, 64'(instr_out), 64'(e.instr));
        check({tag, ".addr"},  64'(addr_out),  64'(e.addr));
    endtask

    // One clocked cycle with reset released; called just after a falling edge.
    task automatic cycle(input string tag, input logic j, input logic [INSTR_W-1:0] ins,
                         input logic [ADDR_W-1:0] a, input logic st);
        exp_t got_exp;
        jump     = j;
        instr_in = ins;
        addr_in  = a;
        stall    = st;
        if (j) begin
            model = '0;
        end else if (!(st && STALL_EN)) begin
            model.instr = ins;
            model.addr  = a;
        end
        sb_q.push_back(model);
        @(posedge clk);
        #1;
        check({tag, ".sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
            got_exp = sb_q.pop_front();
            check_out(tag, got_exp);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        model    = '0;
        rst_n    = 1'b0;
        jump     = 1'b0;
        stall    = 1'b0;
        instr_in = 32'h1234_5678;
        addr_in  = 14'h0001;

        // Reset held: edges (one with jump) must not disturb the outputs.
        #1;
        check_out("rst_initial", '0);
        for (int i = 0; i < 3; i++) begin
            jump = (i == 1);
            @(posedge clk);
            #1;
            check_out("rst_hold", '0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Normal load, flush, then recovery.
        cycle("load1",  1'b0, 32'h1234_5678, 14'h0001, 1'b0);
        cycle("flush1", 1'b1, 32'h0000_0001, 14'h0011, 1'b0);
        cycle("load2",  1'b0, 32'h0000_0001, 14'h0011, 1'b0);

        // Async reset between edges clears immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst_async", '0);
        model = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back flushes give back-to-back bubbles.
        cycle("pre_jj",  1'b0, 32'hCAFE_F00D, 14'h3FFF, 1'b0);
        cycle("jj1",     1'b1, 32'h1111_1111, 14'h0101, 1'b0);
        cycle("jj2",     1'b1, 32'h2222_2222, 14'h0202, 1'b0);
        cycle("post_jj", 1'b0, 32'h3333_3333, 14'h0303, 1'b0);

        // A jump pulse that does not span a rising edge is ignored.
        jump = 1'b1;
        #2;
        jump = 1'b0;
        cycle("glitch", 1'b0, 32'hFFFF_FFFF, 14'h2AAA, 1'b0);

        // Stall holds through changing inputs; jump overrides stall.
        cycle("st_load", 1'b0, 32'hDEAD_BEEF, 14'h0123, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("st_hold", 1'b0, 32'hA000_0000 + 32'(i), 14'(i + 5), 1'b1);
        end
        cycle("st_flush", 1'b1, 32'h5555_5555, 14'h1555, 1'b1);
        cycle("st_after", 1'b0, 32'h0BAD_F00D, 14'h0042, 1'b0);

        // Randomised traffic against the model.
        for (int i = 0; i < 40; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) == 0), $urandom(),
                  14'($urandom()), 1'($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
